// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses PC register data/enable and drives the
// fetch-valid, flush, halted and misaligned status toward fetch/decode.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               PC_STEP      = 4,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int               BOOT_CYCLES  = 1,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_current,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             trap,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_enable,
    output logic             fetch_valid,
    output logic             flush,
    output logic             halted,
    output logic             misaligned
);

    localparam int CMAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]    BOOT_LOAD  = CW'(BOOT_CYCLES - 1);
    localparam logic [CW-1:0]    FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        HALT
    } state_t;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic             mis_nx;
    logic [WIDTH-1:0] tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            cnt        <= BOOT_LOAD;
            misaligned <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            misaligned <= mis_nx;
        end
    end

    // jump outranks branch when both redirect in the same cycle
    assign tgt = jump ? jump_target : branch_target;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        mis_nx      = 1'b0;
        pc_next     = pc_current;
        pc_enable   = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        unique case (state)
            BOOT: begin
                pc_next = '0;
                if (cnt == '0) state_nx = RUN;
                else           cnt_nx   = cnt - CW'(1);
            end
            RUN: begin
                fetch_valid = 1'b1;
                if (trap) begin
                    pc_next   = TRAP_VECTOR;
                    pc_enable = 1'b1;
                    state_nx  = FLUSH;
                    cnt_nx    = FLUSH_LOAD;
                end else if (jump || branch_taken) begin
                    pc_next   = {tgt[WIDTH-1:2], 2'b00};
                    pc_enable = 1'b1;
                    state_nx  = FLUSH;
                    cnt_nx    = FLUSH_LOAD;
                    mis_nx    = |tgt[1:0];
                end else if (halt_req) begin
                    state_nx = HALT;
                end else if (!stall) begin
                    pc_next   = pc_current + STEP;
                    pc_enable = 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                // only a trap may restart the squash window
                if (trap) begin
                    pc_next   = TRAP_VECTOR;
                    pc_enable = 1'b1;
                    cnt_nx    = FLUSH_LOAD;
                end else if (cnt == '0) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            HALT: begin
                halted = 1'b1;
                if (trap) begin
                    pc_next   = TRAP_VECTOR;
                    pc_enable = 1'b1;
                    state_nx  = FLUSH;
                    cnt_nx    = FLUSH_LOAD;
                end else if (resume) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = BOOT;
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized requests
// compared cycle by cycle against a procedural reference model.
module tb_pc_sequencer;

    localparam logic [31:0] TRAPV = 32'h0000_0100;
    localparam int BOOTC = 1;
    localparam int FLUSHC = 2;
    localparam int M_BOOT = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

    logic        clk, rst;
    logic [31:0] pc_current;
    logic        stall, branch_taken, jump, trap, halt_req, resume;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_next;
    logic        pc_enable, fetch_valid, flush, halted, misaligned;

    int checks = 0;
    int errors = 0;

    // sampled DUT outputs
    logic [31:0] s_next;
    logic        s_en, s_fv, s_fl, s_halt, s_mis;

    // reference model
    int          m_mode, m_left;
    logic        m_mis;
    logic [31:0] m_pc;
    int          n_mode, n_left;
    logic        n_mis;
    int          e_mode;
    logic [31:0] e_next;
    logic        e_en, e_fv, e_fl, e_halt, e_mis;

    pc_sequencer #(
        .WIDTH(32), .PC_STEP(4), .TRAP_VECTOR(TRAPV),
        .BOOT_CYCLES(BOOTC), .FLUSH_CYCLES(FLUSHC)
    ) dut (
        .clk(clk), .rst(rst), .pc_current(pc_current), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .trap(trap),
        .halt_req(halt_req), .resume(resume), .pc_next(pc_next),
        .pc_enable(pc_enable), .fetch_valid(fetch_valid), .flush(flush),
        .halted(halted), .misaligned(misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task clr();
        stall = 0; branch_taken = 0; jump = 0; trap = 0;
        halt_req = 0; resume = 0;
        branch_target = 0; jump_target = 0;
    endtask

    task model_reset();
        m_mode = M_BOOT; m_left = BOOTC - 1; m_mis = 0; m_pc = 0;
    endtask

    task set_pc(input logic [31:0] v);
        pc_current = v;
        m_pc = v;
    endtask

    task model_eval();
        logic [31:0] tgt;
        logic        red;
        e_mode = m_mode;
        e_next = m_pc; e_en = 0; e_fv = 0; e_fl = 0; e_halt = 0;
        e_mis = m_mis;
        n_mode = m_mode; n_left = m_left; n_mis = 0;
        tgt = 0; red = 0;
        if (m_mode == M_BOOT) begin
            e_next = 0;
            if (m_left == 0) n_mode = M_RUN;
            else n_left = m_left - 1;
        end else if (m_mode == M_RUN) begin
            e_fv = 1;
            if (trap) begin tgt = TRAPV; red = 1; end
            else if (jump) begin tgt = jump_target; red = 1; end
            else if (branch_taken) begin tgt = branch_target; red = 1; end
            if (red) begin
                e_en = 1;
                e_next = tgt - (tgt % 4);
                n_mode = M_FLUSH; n_left = FLUSHC - 1;
                n_mis = !trap && (tgt % 4 != 0);
            end else if (halt_req) begin
                n_mode = M_HALT;
            end else if (!stall) begin
                e_en = 1;
                e_next = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            end
        end else if (m_mode == M_FLUSH) begin
            e_fl = 1;
            if (trap) begin
                e_en = 1; e_next = TRAPV; n_left = FLUSHC - 1;
            end else if (m_left == 0) n_mode = M_RUN;
            else n_left = m_left - 1;
        end else begin
            e_halt = 1;
            if (trap) begin
                e_en = 1; e_next = TRAPV;
                n_mode = M_FLUSH; n_left = FLUSHC - 1;
            end else if (resume) n_mode = M_RUN;
        end
    endtask

    // one clock: sample at negedge, model step, PC register update after edge
    task tick();
        @(negedge clk);
        s_next = pc_next; s_en = pc_enable; s_fv = fetch_valid;
        s_fl = flush; s_halt = halted; s_mis = misaligned;
        model_eval();
        @(posedge clk);
        #1;
        if (s_en) pc_current = s_next;
        m_mode = n_mode; m_left = n_left; m_mis = n_mis;
        if (e_en) m_pc = e_next;
    endtask

    task test_reset();
        tick();
        tick();
        branch_taken = 1; branch_target = 32'h80;
        tick();
        clr();
        tick();
        rst = 1; pc_current = 0; model_reset();
        #2;
        checks++;
        if ({pc_enable, fetch_valid, flush, halted, misaligned} !== 5'b0) begin
            errors++;
            $display("FAIL rst_outs got en%b fv%b fl%b h%b m%b want all 0",
                     pc_enable, fetch_valid, flush, halted, misaligned);
        end
        checks++;
        if (pc_next !== 32'h0) begin
            errors++; $display("FAIL rst_pcnext got %h want 0", pc_next);
        end
        @(posedge clk); #1; rst = 0;
        tick();
        checks++;
        if (s_en !== 1'b0 || s_next !== 32'h0) begin
            errors++; $display("FAIL boot got en%b next %h want en0 next 0", s_en, s_next);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc_current !== 32'(4 * i)) begin
                errors++; $display("FAIL boot_seq got %h want %h", pc_current, 4 * i);
            end
            if (i < 3) begin
                tick();
                checks++;
                if (s_fv !== 1'b1) begin
                    errors++; $display("FAIL boot_fv got %b want 1", s_fv);
                end
            end
        end
    endtask

    task test_branch();
        set_pc(32'h10);
        branch_taken = 1; branch_target = 32'h40;
        tick();
        clr();
        checks++;
        if (pc_current !== 32'h40) begin
            errors++; $display("FAIL br_pc got %h want 40", pc_current);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_fl !== 1'b1 || s_fv !== 1'b0 || s_en !== 1'b0) begin
                errors++;
                $display("FAIL br_flush%0d got fl%b fv%b en%b want 1 0 0", i, s_fl, s_fv, s_en);
            end
        end
        tick();
        checks++;
        if (pc_current !== 32'h44 || s_fl !== 1'b0) begin
            errors++; $display("FAIL br_resume got %h fl%b want 44 fl0", pc_current, s_fl);
        end
    endtask

    task test_priority();
        set_pc(32'h50);
        jump = 1; jump_target = 32'h43;
        branch_taken = 1; branch_target = 32'h80; stall = 1;
        tick();
        clr();
        checks++;
        if (pc_current !== 32'h40) begin
            errors++; $display("FAIL prio_pc got %h want 40", pc_current);
        end
        tick();
        checks++;
        if (s_mis !== 1'b1) begin
            errors++; $display("FAIL mis_set got %b want 1", s_mis);
        end
        tick();
        checks++;
        if (s_mis !== 1'b0) begin
            errors++; $display("FAIL mis_pulse got %b want 0", s_mis);
        end
    endtask

    task test_stall();
        set_pc(32'h20);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (pc_current !== 32'h20 || s_fv !== 1'b1 || s_en !== 1'b0) begin
                errors++;
                $display("FAIL stall%0d got pc %h fv%b en%b want 20 1 0", i, pc_current, s_fv, s_en);
            end
        end
        stall = 0;
        tick();
        checks++;
        if (pc_current !== 32'h24) begin
            errors++; $display("FAIL stall_rel got %h want 24", pc_current);
        end
    endtask

    task test_halt();
        set_pc(32'h30);
        halt_req = 1;
        tick();
        clr();
        tick();
        checks++;
        if (s_halt !== 1'b1 || s_fv !== 1'b0 || s_en !== 1'b0 || pc_current !== 32'h30) begin
            errors++;
            $display("FAIL halt got h%b fv%b en%b pc %h want 1 0 0 30", s_halt, s_fv, s_en, pc_current);
        end
        resume = 1;
        tick();
        clr();
        tick();
        checks++;
        if (s_halt !== 1'b0 || pc_current !== 32'h34) begin
            errors++; $display("FAIL resume got h%b pc %h want 0 34", s_halt, pc_current);
        end
        halt_req = 1;
        tick();
        clr();
        trap = 1; resume = 1;
        tick();
        clr();
        checks++;
        if (pc_current !== TRAPV) begin
            errors++; $display("FAIL halt_trap got %h want 100", pc_current);
        end
        tick();
        checks++;
        if (s_fl !== 1'b1 || s_halt !== 1'b0) begin
            errors++; $display("FAIL halt_trap_fl got fl%b h%b want 1 0", s_fl, s_halt);
        end
        tick();
    endtask

    task test_wrap_trap_flush();
        set_pc(32'hFFFF_FFFC);
        tick();
        checks++;
        if (pc_current !== 32'h0) begin
            errors++; $display("FAIL wrap got %h want 0", pc_current);
        end
        branch_taken = 1; branch_target = 32'h200;
        tick();
        clr();
        tick();
        trap = 1;
        tick();
        clr();
        checks++;
        if (s_fl !== 1'b1 || s_en !== 1'b1 || pc_current !== TRAPV) begin
            errors++;
            $display("FAIL fl_trap got fl%b en%b pc %h want 1 1 100", s_fl, s_en, pc_current);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_fl !== 1'b1 || s_en !== 1'b0) begin
                errors++; $display("FAIL fl_trap_ext%0d got fl%b en%b want 1 0", i, s_fl, s_en);
            end
        end
        tick();
        checks++;
        if (s_fl !== 1'b0 || pc_current !== 32'h104) begin
            errors++; $display("FAIL fl_trap_end got fl%b pc %h want 0 104", s_fl, pc_current);
        end
    endtask

    task test_random();
        for (int i = 0; i < 600; i++) begin
            trap = ($urandom_range(15) == 0);
            jump = ($urandom_range(9) == 0);
            branch_taken = ($urandom_range(7) == 0);
            halt_req = ($urandom_range(19) == 0);
            resume = ($urandom_range(2) == 0);
            stall = ($urandom_range(3) == 0);
            jump_target = $urandom();
            branch_target = $urandom();
            tick();
            checks++;
            if ({s_en, s_fv, s_fl, s_halt, s_mis} !== {e_en, e_fv, e_fl, e_halt, e_mis}) begin
                errors++;
                $display("FAIL rnd_ctl cyc %0d got %b want %b", i,
                         {s_en, s_fv, s_fl, s_halt, s_mis}, {e_en, e_fv, e_fl, e_halt, e_mis});
            end
            if (e_en || e_mode == M_BOOT) begin
                checks++;
                if (s_next !== e_next) begin
                    errors++; $display("FAIL rnd_next cyc %0d got %h want %h", i, s_next, e_next);
                end
            end
            checks++;
            if (pc_current !== m_pc) begin
                errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc_current, m_pc);
            end
        end
        clr();
    endtask

    initial begin
        rst = 1;
        clr();
        pc_current = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        test_reset();
        test_branch();
        test_priority();
        test_stall();
        test_halt();
        test_wrap_trap_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
